du_loader: RTL and testbench



---
 rtl/du_pkg.sv | 14 +
 rtl/du_loader.sv | 101 ++++++++++
 tb/tb_du_loader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/du_pkg.sv
// du_pkg: debug-unit protocol bytes, halt instruction and IMEM write-size encodings
package du_pkg;
  localparam logic [7:0] ACK  = 8'h05;
  localparam logic [7:0] NAK  = 8'h15;
  localparam logic [7:0] SOT  = 8'h01;
  localparam logic [7:0] EOT  = 8'h04;
  localparam logic [7:0] CONT = 8'h06;
  localparam logic [7:0] STEP = 8'h07;
  localparam logic [31:0] HALT_INSTR = 32'h1A1A1A1A;
  localparam logic [1:0] SIZE_NONE = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;
endpackage

// File: rtl/du_loader.sv
// du_loader: streams UART RX bytes into IMEM as little-endian words, ACKing each word until HALT or overflow
module du_loader
  import du_pkg::*;
#(
  parameter int NB_INSTRUCTION = 32,
  parameter int NB_UART_DATA   = 8,
  parameter int NB_IMEM_ADDR   = 10
) (
  input  logic                      clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [NB_UART_DATA-1:0]   i_rx_data,
  input  logic                      i_rx_done,
  input  logic                      i_tx_full,
  output logic                      o_rd,
  output logic                      o_wr,
  output logic [NB_UART_DATA-1:0]   o_wdata,
  output logic                      o_tx_start,
  output logic                      o_imem_we,
  output logic [NB_IMEM_ADDR-1:0]   o_imem_waddr,
  output logic [NB_INSTRUCTION-1:0] o_imem_wdata,
  output logic [1:0]                o_imem_wsize,
  output logic                      o_done,
  output logic                      o_error
);
  typedef enum logic [2:0] {S_IDLE, S_RX, S_WRITE, S_ACK, S_ERR, S_DONE} state_t;
  localparam logic [NB_IMEM_ADDR-1:0] LAST_ADDR = ~NB_IMEM_ADDR'(3);
  state_t                    state_q, state_d;
  logic [NB_IMEM_ADDR-1:0]   addr_q, addr_d;
  logic [1:0]                idx_q, idx_d;
  logic [NB_INSTRUCTION-1:0] word_q, word_d;
  logic                      err_q, err_d;
  logic                      we;
  logic                      tx_go;
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end
  // Dropping i_start aborts any active state; IDLE and DONE handle it themselves.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    word_d  = word_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (i_start) begin
        state_d = S_RX;
        addr_d  = '0;
        idx_d   = '0;
        err_d   = 1'b0;
      end
      S_RX: if (!i_start) state_d = S_IDLE;
        else if (i_rx_done) begin
          word_d[NB_UART_DATA*idx_q +: NB_UART_DATA] = i_rx_data;
          idx_d = idx_q + 2'd1;
          state_d = (idx_q == 2'd3) ? S_WRITE : S_RX;
        end
      S_WRITE: if (!i_start) state_d = S_IDLE;
        else if (word_q == NB_INSTRUCTION'(HALT_INSTR)) state_d = S_DONE;
        else if (addr_q == LAST_ADDR) state_d = S_ERR;
        else begin
          state_d = S_ACK;
          addr_d  = addr_q + NB_IMEM_ADDR'(4);
        end
      S_ACK: state_d = !i_start ? S_IDLE : !i_tx_full ? S_RX : S_ACK;
      S_ERR: if (!i_start) state_d = S_IDLE;
        else if (!i_tx_full) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      S_DONE: state_d = i_start ? S_DONE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    we           = (state_q == S_WRITE) && i_start;
    tx_go        = ((state_q == S_ACK) || (state_q == S_ERR)) && i_start && !i_tx_full;
    o_rd         = (state_q == S_RX) && i_start && i_rx_done;
    o_imem_we    = we;
    o_imem_waddr = we ? addr_q : '0;
    o_imem_wdata = we ? word_q : '0;
    o_imem_wsize = we ? SIZE_WORD : SIZE_NONE;
    o_wr         = tx_go;
    o_tx_start   = tx_go;
    o_wdata      = !tx_go ? '0 : (state_q == S_ERR) ? NB_UART_DATA'(NAK) : NB_UART_DATA'(ACK);
    o_done       = (state_q == S_DONE);
    o_error      = (state_q == S_DONE) && err_q;
  end
endmodule

// File: tb/tb_du_loader.sv
// tb_du_loader: randomized scoreboard bench for du_loader with a word-level reference model
module tb_du_loader;
  localparam int AW  = 4;
  localparam int CAP = 1 << AW;
  localparam logic [31:0] HALT = 32'h1A1A1A1A;
  logic clk = 1'b0;
  logic i_rst_n, i_start, i_rx_done, i_tx_full;
  logic [7:0] i_rx_data;
  logic o_rd, o_wr, o_tx_start, o_imem_we, o_done, o_error;
  logic [7:0] o_wdata;
  logic [AW-1:0] o_imem_waddr;
  logic [31:0] o_imem_wdata;
  logic [1:0] o_imem_wsize;
  int errors = 0, checks = 0;
  logic [7:0] rx_q[$];
  logic [7:0] bq[$];
  int exp_a[$];
  logic [31:0] exp_d[$];
  logic [7:0] exp_t[$];
  int pops = 0, gap_at = -1, gap_left = 0, cnt = 0, last_rd = 0;
  logic pend_rd = 1'b0, start_n = 1'b0, full_n = 1'b0;
  du_loader #(.NB_IMEM_ADDR(AW)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_rx_data(i_rx_data),
    .i_rx_done(i_rx_done), .i_tx_full(i_tx_full), .o_rd(o_rd), .o_wr(o_wr),
    .o_wdata(o_wdata), .o_tx_start(o_tx_start), .o_imem_we(o_imem_we),
    .o_imem_waddr(o_imem_waddr), .o_imem_wdata(o_imem_wdata),
    .o_imem_wsize(o_imem_wsize), .o_done(o_done), .o_error(o_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, r);
    end
  endtask
  // Scoreboard monitor: samples on the falling edge, inputs only move just after the rising edge.
  always @(negedge clk) begin
    cnt++;
    pend_rd = o_rd;
    if (o_rd) begin
      last_rd = cnt;
      chk("rd_needs_data", i_rx_done, 1);
    end
    if (o_imem_we) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL imem_unexpected actual addr=%0h data=%0h required=no write", o_imem_waddr, o_imem_wdata);
      end else begin
        chk("imem_addr", o_imem_waddr, exp_a.pop_front());
        chk("imem_data", o_imem_wdata, exp_d.pop_front());
        chk("imem_size", o_imem_wsize, 2'b11);
        chk("imem_latency", cnt - last_rd, 1);
      end
    end
    if (o_wr) begin
      chk("tx_start", o_tx_start, 1);
      chk("tx_while_full", i_tx_full, 0);
      if (exp_t.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected actual=%0h required=no byte", o_wdata);
      end else chk("tx_byte", o_wdata, exp_t.pop_front());
    end
  end
  task automatic drive();
    i_start   = start_n;
    i_tx_full = full_n;
    i_rx_done = (rx_q.size() > 0) && !(gap_left > 0 && pops == gap_at);
    i_rx_data = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    if (pend_rd && rx_q.size() > 0) begin
      void'(rx_q.pop_front());
      pops++;
    end
    if (gap_left > 0 && pops == gap_at) gap_left--;
    drive();
    @(negedge clk);
    #1;
  endtask
  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) bq.push_back(w[8*i +: 8]);
  endtask
  // Reference: the byte stream is cut into words; word k goes to 4k, HALT ends it, the last slot NAKs.
  task automatic model(input logic [7:0] b[$], output logic e, output int np);
    logic [31:0] w;
    e = 1'b0;
    np = 0;
    for (int k = 0; k < b.size() / 4; k++) begin
      w = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
      exp_a.push_back(4 * k);
      exp_d.push_back(w);
      np += 4;
      if (w == HALT) return;
      if (4 * k == CAP - 4) begin
        exp_t.push_back(8'h15);
        e = 1'b1;
        return;
      end
      exp_t.push_back(8'h05);
    end
  endtask
  task automatic do_load(input int g_at, input int g_len, input bit arm_full, input bit rnd_full);
    logic e;
    int np, t;
    bit armed;
    model(bq, e, np);
    pops = 0;
    gap_at = g_at;
    gap_left = g_len;
    armed = arm_full;
    foreach (bq[i]) rx_q.push_back(bq[i]);
    start_n = 1'b1;
    t = 0;
    while (!o_done && t < 3000) begin
      cyc();
      t++;
      if (rnd_full) full_n = ($urandom_range(0, 2) == 0);
      if (armed && o_imem_we) begin
        armed = 1'b0;
        full_n = 1'b1;
        repeat (10) begin
          cyc();
          chk("stall_wr", o_wr, 0);
          chk("stall_rd", o_rd, 0);
        end
        full_n = 1'b0;
        cyc();
        chk("ack_after_full", o_wr, 1);
      end
    end
    chk("done", o_done, 1);
    chk("error", o_error, e);
    chk("pops", pops, np);
    chk("unread", rx_q.size(), bq.size() - np);
    chk("sb_empty", exp_a.size() + exp_t.size(), 0);
    repeat (3) cyc();
    chk("done_hold", {o_done, o_rd, o_wr, o_imem_we}, 4'b1000);
    start_n = 1'b0;
    full_n = 1'b0;
    rx_q.delete();
    cyc();
    cyc();
    chk("done_clear", o_done, 0);
    bq.delete();
  endtask
  task automatic basic_bytes();
    bq = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h1A, 8'h1A, 8'h1A, 8'h1A};
  endtask
  initial begin
    int t;
    logic e;
    int np;
    i_rst_n = 1'b0;
    drive();
    @(negedge clk);
    #1;
    chk("reset_outputs", {o_rd, o_wr, o_wdata, o_tx_start, o_imem_we, o_imem_waddr, o_imem_wdata, o_imem_wsize, o_done, o_error}, 0);
    i_rst_n = 1'b1;
    cyc();
    basic_bytes();
    do_load(-1, 0, 0, 0);
    basic_bytes();
    do_load(2, 20, 0, 0);
    basic_bytes();
    do_load(-1, 0, 1, 0);
    for (int k = 0; k < 5; k++) push_word(32'h01020304 * (k + 1));
    do_load(-1, 0, 0, 0);
    for (int k = 0; k < 3; k++) push_word(32'h00A00093 + k);
    push_word(HALT);
    do_load(-1, 0, 0, 0);
    // Abort after two bytes of the second word, then restart from address 0.
    bq = '{8'h13, 8'h00, 8'h10, 8'h00, 8'hAA, 8'hBB};
    model(bq, e, np);
    foreach (bq[i]) rx_q.push_back(bq[i]);
    bq.delete();
    pops = 0;
    start_n = 1'b1;
    t = 0;
    while (pops < 6 && t < 500) begin cyc(); t++; end
    repeat (3) cyc();
    chk("abort_pre_pops", pops, 6);
    chk("abort_pre_sb", exp_a.size() + exp_t.size(), 0);
    start_n = 1'b0;
    repeat (3) begin
      cyc();
      chk("abort_no_done", {o_done, o_imem_we}, 0);
    end
    rx_q.delete();
    basic_bytes();
    do_load(-1, 0, 0, 0);
    // Asynchronous reset between edges in the middle of a word.
    basic_bytes();
    foreach (bq[i]) rx_q.push_back(bq[i]);
    bq.delete();
    void'(exp_a.size());
    pops = 0;
    start_n = 1'b1;
    t = 0;
    while (pops < 2 && t < 500) begin cyc(); t++; end
    chk("pre_reset_rd", o_rd, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {o_rd, o_wr, o_wdata, o_tx_start, o_imem_we, o_imem_waddr, o_imem_wdata, o_imem_wsize, o_done, o_error}, 0);
    start_n = 1'b0;
    i_start = 1'b0;
    rx_q.delete();
    cyc();
    cyc();
    i_rst_n = 1'b1;
    cyc();
    basic_bytes();
    do_load(-1, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      int nw;
      nw = $urandom_range(1, 5);
      for (int k = 0; k < nw - 1; k++) push_word({$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 8'($urandom_range(0, 25))});
      if (nw < 5) push_word(HALT);
      else push_word(32'h12345678);
      repeat ($urandom_range(0, 3)) bq.push_back(8'($urandom_range(0, 255)));
      do_load(-1, 0, 0, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
